// File: rtl/atm_txn_controller.sv
// atm_txn_controller: ATM session sequencer.
// Handles card scan, PIN check with a retry limit and option select. It then
// runs one balance, withdraw, deposit, transfer, exit or new-PIN operation per
// request. The balance and PIN registers live here and persist across sessions.
// Optional feature macro: ATM_TIMEOUT_EN. When defined, an inactivity timeout
// ejects the card from the PIN, option or new-PIN wait states.
module atm_txn_controller #(
  parameter int unsigned      AMT_W       = 16,
  parameter int unsigned      PIN_W       = 16,
  parameter logic [AMT_W-1:0] INIT_BAL    = AMT_W'(1000),
  parameter logic [PIN_W-1:0] INIT_PIN    = PIN_W'(16'h1234),
  parameter int unsigned      MAX_TRIES   = 3,
  parameter int unsigned      TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_in,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             op_valid,
  input  logic [3:0]       op_code,
  input  logic [AMT_W-1:0] amount,
  output logic             op_ready,
  output logic [3:0]       state_o,
  output logic [AMT_W-1:0] balance_o,
  output logic             bal_valid,
  output logic             dispense_valid,
  output logic [AMT_W-1:0] dispense_amt,
  output logic             xfer_valid,
  output logic [AMT_W-1:0] xfer_amt,
  output logic             err_o,
  output logic [1:0]       err_code,
  output logic             card_eject,
  output logic             card_retain
);

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_BALANCE_CHECK = 4'd1,
    S_WITHDRAW      = 4'd2,
    S_DEPOSIT       = 4'd3,
    S_TRANSFER      = 4'd4,
    S_EXIT          = 4'd5,
    S_NEW_PASS      = 4'd6,
    S_SCAN_CARD     = 4'd8,
    S_ENTER_PASS    = 4'd9,
    S_OPTION_SELECT = 4'd10
  } state_t;

  localparam int unsigned TRY_W     = 3;
  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);
  localparam logic [1:0] ERR_PIN   = 2'd0;
  localparam logic [1:0] ERR_FUNDS = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_OP    = 2'd3;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   bal_q, bal_d;
  logic [PIN_W-1:0]   pin_q, pin_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic [AMT_W:0]     sum;
  logic               lockout;

  logic               op_ready_d, bal_valid_d, disp_valid_d, xfer_valid_d;
  logic [AMT_W-1:0]   disp_amt_d, xfer_amt_d;
  logic               err_d, eject_d, retain_d;
  logic [1:0]         err_code_d;
  logic               timed_out;

  assign state_o   = state_q;
  assign balance_o = bal_q;

`ifdef ATM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            waiting;

  // Inactivity counter: restarts on any request or state change, saturates at the limit
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (pin_valid || op_valid || (state_d != state_q)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_W'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Timeout applies only while waiting on the customer
  always_comb begin
    waiting   = (state_q == S_ENTER_PASS) || (state_q == S_OPTION_SELECT) ||
                (state_q == S_NEW_PASS);
    timed_out = waiting && !pin_valid && !op_valid &&
                (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  end

  // Inactivity counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout feature TIMEOUT_CYC has no effect.
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign timed_out = 1'b0;
`endif

  // Next-state, datapath update and next strobe values
  always_comb begin
    state_d      = state_q;
    bal_d        = bal_q;
    pin_d        = pin_q;
    tries_d      = tries_q;
    amt_d        = amt_q;
    bal_valid_d  = 1'b0;
    disp_valid_d = 1'b0;
    disp_amt_d   = '0;
    xfer_valid_d = 1'b0;
    xfer_amt_d   = '0;
    err_d        = 1'b0;
    err_code_d   = err_code;
    eject_d      = 1'b0;
    retain_d     = 1'b0;
    lockout      = 1'b0;
    sum          = {1'b0, bal_q} + {1'b0, amt_q};

    if (!card_in && (state_q != S_IDLE) && (state_q != S_EXIT)) begin
      // Card pulled: abandon whatever is in flight and eject
      state_d = S_EXIT;
    end else if (timed_out) begin
      state_d = S_EXIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_in) state_d = S_SCAN_CARD;
        end
        S_SCAN_CARD: begin
          tries_d = '0;
          state_d = S_ENTER_PASS;
        end
        S_ENTER_PASS: begin
          if (pin_valid) begin
            if (pin_in == pin_q) begin
              state_d = S_OPTION_SELECT;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_PIN;
              tries_d    = tries_q + TRY_W'(1);
              if (tries_d == MAX_T) begin
                lockout = 1'b1;
                state_d = S_EXIT;
              end
            end
          end
        end
        S_OPTION_SELECT: begin
          if (op_valid) begin
            if ((op_code >= 4'd1) && (op_code <= 4'd6)) begin
              state_d = state_t'(op_code);
              amt_d   = amount;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_OP;
            end
          end
        end
        S_BALANCE_CHECK: begin
          bal_valid_d = 1'b1;
          state_d     = S_OPTION_SELECT;
        end
        S_WITHDRAW, S_TRANSFER: begin
          state_d = S_OPTION_SELECT;
          if (amt_q <= bal_q) begin
            bal_d = bal_q - amt_q;
            if (state_q == S_WITHDRAW) begin
              disp_valid_d = 1'b1;
              disp_amt_d   = amt_q;
            end else begin
              xfer_valid_d = 1'b1;
              xfer_amt_d   = amt_q;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_FUNDS;
          end
        end
        S_DEPOSIT: begin
          state_d = S_OPTION_SELECT;
          if (sum[AMT_W]) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
          end else begin
            bal_d = sum[AMT_W-1:0];
          end
        end
        S_NEW_PASS: begin
          if (pin_valid) begin
            pin_d   = pin_in;
            state_d = S_OPTION_SELECT;
          end
        end
        S_EXIT: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Card strobes are registered on entry so they coincide with the EXIT cycle
    if ((state_d == S_EXIT) && (state_q != S_EXIT)) begin
      retain_d = lockout;
      eject_d  = !lockout;
    end
    op_ready_d = (state_d == S_OPTION_SELECT);
  end

  // State, account registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      bal_q          <= INIT_BAL;
      pin_q          <= INIT_PIN;
      tries_q        <= '0;
      amt_q          <= '0;
      op_ready       <= 1'b0;
      bal_valid      <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_amt   <= '0;
      xfer_valid     <= 1'b0;
      xfer_amt       <= '0;
      err_o          <= 1'b0;
      err_code       <= 2'd0;
      card_eject     <= 1'b0;
      card_retain    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bal_q          <= bal_d;
      pin_q          <= pin_d;
      tries_q        <= tries_d;
      amt_q          <= amt_d;
      op_ready       <= op_ready_d;
      bal_valid      <= bal_valid_d;
      dispense_valid <= disp_valid_d;
      dispense_amt   <= disp_amt_d;
      xfer_valid     <= xfer_valid_d;
      xfer_amt       <= xfer_amt_d;
      err_o          <= err_d;
      err_code       <= err_code_d;
      card_eject     <= eject_d;
      card_retain    <= retain_d;
    end
  end

endmodule
